// File: rtl/ucode_pkg.sv
// Shared definitions for the microcode sequencer: ALU select codes, control
// word field positions, FSM state encodings and the default ALU test program.
package ucode_pkg;

  // ALU operation select codes carried in the alu_sel field
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b11;

  // Field positions inside the base 4-bit control word
  localparam int BASE_CTRL_W = 4;
  localparam int ALU_SEL_HI  = 3;
  localparam int ALU_SEL_LO  = 2;
  localparam int MUX_SEL_BIT = 1;
  localparam int LOAD_BIT    = 0;

  // No-operation word: ALU AND, mux 0, accumulator not loaded
  localparam logic [BASE_CTRL_W-1:0] CTRL_NOP = '0;

  // Sequencer states, kept as plain constants for the legacy tooling
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Packs the individual control fields into a base control word
  function automatic logic [BASE_CTRL_W-1:0] make_word(input logic [1:0] alu,
                                                       input logic       mux,
                                                       input logic       load);
    logic [BASE_CTRL_W-1:0] w;
    w = CTRL_NOP;
    w[ALU_SEL_HI:ALU_SEL_LO] = alu;
    w[MUX_SEL_BIT]           = mux;
    w[LOAD_BIT]              = load;
    return w;
  endfunction

  // Default ALU test program, indexed by store address; unused entries are NOPs
  function automatic logic [BASE_CTRL_W-1:0] default_word(input int unsigned addr);
    logic [BASE_CTRL_W-1:0] w;
    case (addr)
      0:       w = make_word(ALU_AND, 1'b0, 1'b1);
      1:       w = make_word(ALU_XOR, 1'b0, 1'b1);
      2:       w = make_word(ALU_ADD, 1'b0, 1'b1);
      3:       w = make_word(ALU_ADD, 1'b1, 1'b1);
      4:       w = make_word(ALU_ADD, 1'b1, 1'b1);
      5:       w = make_word(ALU_XOR, 1'b0, 1'b1);
      6:       w = make_word(ALU_ADD, 1'b0, 1'b1);
      default: w = CTRL_NOP;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ucode_store.sv
// Writable control store: DEPTH x CTRL_W register file that reverts to the
// default program on reset, with one synchronous write and one async read port.
module ucode_store
  import ucode_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CTRL_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CTRL_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [CTRL_W-1:0] mem [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    // Reset value is the default program word, zero-extended to CTRL_W
    localparam logic [CTRL_W-1:0] RST_VAL = CTRL_W'(default_word(g));

    logic [CTRL_W-1:0] entry;

    // Each entry reloads its default on reset and captures writes to its address
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry <= RST_VAL;
      end else if (wr_en && (wr_addr == ADDR_W'(g))) begin
        entry <= wr_data;
      end
    end

    assign mem[g] = entry;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: steps a program counter through the control store and
// issues one registered control word per issue cycle, with run, single-step
// and loop modes plus an abort path.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              step_mode,
  input  logic              step,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CTRL_W-1:0] wr_data,
  output logic              wr_err,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ctrl_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] last_q;
  logic [CTRL_W-1:0] store_word;
  logic              running;
  logic              issue;
  logic              at_last;
  logic              wr_accept;

  assign running   = (state == ST_RUN);
  assign issue     = step_mode ? step : 1'b1;
  assign at_last   = (pc == last_q);
  // The store is frozen while a program runs, so the issued stream is stable
  assign wr_accept = wr_en && !running;

  ucode_store #(
    .ADDR_W (ADDR_W),
    .CTRL_W (CTRL_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (pc),
    .rd_data (store_word)
  );

  // Sequencer FSM: start/stop handling, pc stepping and the issued word register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      last_q     <= '0;
      ctrl_out   <= '0;
      ctrl_valid <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (stop) begin
            state      <= ST_IDLE;
            pc         <= '0;
            ctrl_out   <= '0;
            ctrl_valid <= 1'b0;
          end else if (issue) begin
            ctrl_out   <= store_word;
            ctrl_valid <= 1'b1;
            if (at_last) begin
              pc <= '0;
              if (!loop_en) begin
                state <= ST_DONE;
              end
            end else begin
              pc <= pc + 1'b1;
            end
          end else begin
            ctrl_out   <= '0;
            ctrl_valid <= 1'b0;
          end
        end
        ST_IDLE, ST_DONE: begin
          ctrl_out   <= '0;
          ctrl_valid <= 1'b0;
          if (start && !stop) begin
            state  <= ST_RUN;
            pc     <= '0;
            last_q <= last_addr;
          end
        end
        default: begin
          state      <= ST_IDLE;
          pc         <= '0;
          ctrl_out   <= '0;
          ctrl_valid <= 1'b0;
        end
      endcase
    end
  end

  // Flags a write that arrived while running; the write itself is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && running;
    end
  end

  assign busy = running;
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed testbench for ucode_sequencer: run, loop, single-step, store writes,
// async reset and write-with-start cases against hand-computed words.
module tb_ucode_sequencer;

  localparam int ADDR_W = 3;
  localparam int CTRL_W = 4;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, stop, step_mode, step, loop_en, wr_en;
  logic [ADDR_W-1:0] last_addr, wr_addr;
  logic [CTRL_W-1:0] wr_data;
  logic              wr_err, ctrl_valid, busy, done;
  logic [CTRL_W-1:0] ctrl_out;
  logic [ADDR_W-1:0] pc;

  int checks = 0;
  int passed = 0;

  logic [CTRL_W-1:0] dflt [DEPTH];
  logic [CTRL_W-1:0] model_mem [DEPTH];

  typedef struct {
    logic              step;
    logic [CTRL_W-1:0] exp_ctrl;
    logic              exp_valid;
    logic [ADDR_W-1:0] exp_pc;
  } step_vec_t;

  step_vec_t vecs [8];

  ucode_sequencer #(
    .ADDR_W (ADDR_W),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .step_mode  (step_mode),
    .step       (step),
    .loop_en    (loop_en),
    .last_addr  (last_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .ctrl_out   (ctrl_out),
    .ctrl_valid (ctrl_valid),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Drives one cycle of pulse inputs, waits past the edge, then clears the pulses
  task automatic applyStimulus(input logic a_start, input logic a_stop, input logic a_step,
                               input logic a_wr_en, input logic [ADDR_W-1:0] a_wr_addr,
                               input logic [CTRL_W-1:0] a_wr_data);
    start   = a_start;
    stop    = a_stop;
    step    = a_step;
    wr_en   = a_wr_en;
    wr_addr = a_wr_addr;
    wr_data = a_wr_data;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Starts a free-run program and checks n issued words against the model store
  task automatic runWords(input string tag, input int n, input int err_at);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == err_at) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'b1111);
      else idleCycle();
      checkOutput($sformatf("%s_word%0d", tag, i), 32'(ctrl_out), 32'(model_mem[i % DEPTH]));
      checkOutput($sformatf("%s_valid%0d", tag, i), 32'(ctrl_valid), 32'd1);
      if (err_at >= 0 && i == err_at) checkOutput({tag, "_wr_err_pulse"}, 32'(wr_err), 32'd1);
      if (err_at >= 0 && i == err_at + 1) checkOutput({tag, "_wr_err_clear"}, 32'(wr_err), 32'd0);
    end
  endtask

  initial begin
    dflt = '{4'b0001, 4'b1001, 4'b1101, 4'b1111, 4'b1111, 4'b1001, 4'b1101, 4'b0000};
    model_mem = dflt;
    // Single-step pattern: pulses with idle gaps of 0, 3 and 1 cycles
    vecs[0] = '{1'b1, 4'b0001, 1'b1, 3'd1};
    vecs[1] = '{1'b1, 4'b1001, 1'b1, 3'd2};
    vecs[2] = '{1'b0, 4'b0000, 1'b0, 3'd2};
    vecs[3] = '{1'b0, 4'b0000, 1'b0, 3'd2};
    vecs[4] = '{1'b0, 4'b0000, 1'b0, 3'd2};
    vecs[5] = '{1'b1, 4'b1101, 1'b1, 3'd3};
    vecs[6] = '{1'b0, 4'b0000, 1'b0, 3'd3};
    vecs[7] = '{1'b1, 4'b1111, 1'b1, 3'd4};

    rst = 1'b1; start = 0; stop = 0; step_mode = 0; step = 0; loop_en = 0;
    wr_en = 0; last_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ctrl_out", 32'(ctrl_out), 32'd0);
    checkOutput("rst_valid", 32'(ctrl_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_wr_err", 32'(wr_err), 32'd0);
    rst = 1'b0;
    idleCycle();

    // Full default program, no loop
    last_addr = 3'd6; loop_en = 1'b0;
    runWords("t1", 7, -1);
    checkOutput("t1_done_level", 32'(done), 32'd1);
    idleCycle();
    checkOutput("t1_done_after", 32'(done), 32'd1);
    checkOutput("t1_nop_after", 32'(ctrl_out), 32'd0);
    checkOutput("t1_valid_after", 32'(ctrl_valid), 32'd0);
    checkOutput("t1_busy_after", 32'(busy), 32'd0);

    // Loop over 0..2 then abort
    last_addr = 3'd2; loop_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 7; i++) begin
      idleCycle();
      checkOutput($sformatf("t2_word%0d", i), 32'(ctrl_out), 32'(dflt[i % 3]));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput("t2_stop_valid", 32'(ctrl_valid), 32'd0);
    checkOutput("t2_stop_busy", 32'(busy), 32'd0);
    checkOutput("t2_stop_pc", 32'(pc), 32'd0);
    checkOutput("t2_stop_done", 32'(done), 32'd0);
    loop_en = 1'b0;

    // Single-step mode
    step_mode = 1'b1; last_addr = 3'd6;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("t3_pc_start", 32'(pc), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, vecs[i].step, 1'b0, '0, '0);
      checkOutput($sformatf("t3_ctrl%0d", i), 32'(ctrl_out), 32'(vecs[i].exp_ctrl));
      checkOutput($sformatf("t3_valid%0d", i), 32'(ctrl_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("t3_pc%0d", i), 32'(pc), 32'(vecs[i].exp_pc));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput("t3_stop_busy", 32'(busy), 32'd0);
    step_mode = 1'b0;

    // IDLE write of entry 7, full-depth run with a rejected write, then readback
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 4'b0101);
    model_mem[7] = 4'b0101;
    checkOutput("t4_idle_wr_err", 32'(wr_err), 32'd0);
    last_addr = 3'd7;
    runWords("t4run", 8, 2);
    checkOutput("t4_done", 32'(done), 32'd1);
    runWords("t4rb", 8, -1);

    // Async reset at pc=3, then rerun showing defaults restored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) idleCycle();
    checkOutput("t5_pc_before_rst", 32'(pc), 32'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_async_ctrl", 32'(ctrl_out), 32'd0);
    checkOutput("t5_async_busy", 32'(busy), 32'd0);
    checkOutput("t5_async_valid", 32'(ctrl_valid), 32'd0);
    checkOutput("t5_async_pc", 32'(pc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_mem = dflt;
    runWords("t5", 8, -1);

    // start+stop together in DONE is ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput("t6_startstop_done", 32'(done), 32'd1);
    checkOutput("t6_startstop_busy", 32'(busy), 32'd0);

    // Write and start on the same edge from DONE
    last_addr = 3'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'b1101);
    checkOutput("t6_busy", 32'(busy), 32'd1);
    idleCycle();
    checkOutput("t6_first_word", 32'(ctrl_out), 32'(4'b1101));
    idleCycle();
    checkOutput("t6_second_word", 32'(ctrl_out), 32'(4'b1001));
    checkOutput("t6_done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
